mup_poll: RTL and testbench
===========================

# mup_poll

Polling scheduler for the remote control-panel (MUP) bus, directly upstream of the single-transaction RS-485 exchanger `mup_io`. It sweeps panel addresses 0..N_MUP-1, drives one `mup_io` exchange per panel, and keeps per-panel LED, button, analog and link-status registers. The host sees a register file: it writes LED words and reads the latest button/analog data plus link health, without handling the bus itself.

## Interface
- N_MUP, 8: number of panels polled, 1..8; addresses 0..N_MUP-1.
- GAP, 1000: idle clocks between the end of one exchange and the next start, ≥1.
- clk  in  1  system clock; same clock as `mup_io`.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  polling enable.
- led_wr  in  1  host LED write strobe, one cycle.
- led_addr  in  3  panel address for led_wr.
- led_data  in  16  LED word for led_wr.
- rd_addr  in  3  host read address.
- rd_but  out  16  stored button word of rd_addr.
- rd_an  out  24  stored analog word of rd_addr.
- rd_stat  out  4  {online, fail_cnt[2:0]} of rd_addr.
- cycle_done  out  1  one-cycle pulse after the exchange with address N_MUP-1 completes.
- io_start  out  1  to `mup_io` start.
- io_n_mup  out  3  to `mup_io` n_mup.
- io_led  out  16  to `mup_io` led.
- io_busy, io_error, io_answer  in  1 each  from `mup_io`.
- io_but  in  16; io_an  in  24  from `mup_io`.

## Operation
- Storage: led[N_MUP]×16, but[N_MUP]×16, an[N_MUP]×24, fail_cnt[N_MUP]×3, online[N_MUP]×1. Addresses ≥N_MUP: writes ignored, reads return 0.
- FSM states:
  - IDLE: addr←0. Go to LOAD when enable=1.
  - LOAD: io_n_mup←addr, io_led←led[addr] (latched copy), then START.
  - START: io_start=1 until io_busy=1, then WAIT. If io_busy is not seen within 4 clocks, record a failure and go to NEXT.
  - WAIT: io_start=0. On io_busy=0, go to STORE.
  - STORE: one cycle. Success = io_answer & ~io_error.
    - Success: but[addr]←io_but, an[addr]←io_an, fail_cnt←0, online←1.
    - Failure: fail_cnt saturating +1 (max 7); online←0 once the new fail_cnt ≥3. but/an are kept.
  - NEXT: if addr=N_MUP-1, addr←0 and pulse cycle_done; else addr+1. Go to GAPW.
  - GAPW: count GAP clocks. Then go to LOAD if enable=1, else IDLE.
- enable deassertion never aborts an exchange. The current exchange completes through STORE, then the FSM goes to IDLE. The next enable restarts from address 0.
- led_wr is accepted in any state. If led_addr equals the address being polled, io_led does not change; the new word goes out on the next poll of that address.
- Reads are registered with 1-cycle latency. A read of the address written in the same cycle returns the old value.
- Reset mid-exchange: all state clears and the FSM returns to IDLE; io_start drops immediately. `mup_io` is reset by the same rst.

## Timing
- Reset values: io_start=0, io_n_mup=0, io_led=0, cycle_done=0, rd_*=0. All storage is 0, so every panel starts offline.
- io_start rises 2 clocks after leaving IDLE/GAPW (LOAD, then START). With `mup_io`, io_busy rises 2 clocks after io_start.
- Exchange length is set by `mup_io`: about 132 transmit clocks, plus reply bytes or a 64-clock timeout. The poller adds 4 clocks of overhead (LOAD, START, STORE, NEXT), plus GAP.
- io_n_mup and io_led are stable from LOAD until the next LOAD.
- cycle_done goes high in the cycle after STORE of address N_MUP-1.

## Test plan
- Panel model answers address 2 with but=16'hA55A, an=24'h123456, correct parity; N_MUP=4 -> after one sweep, rd_addr=2 gives rd_but=A55A, rd_an=123456, rd_stat=4'b1000; addresses 0, 1, 3 give rd_stat=4'b0001; cycle_done pulses once per sweep.
- Parity error injected on address 1 for 3 consecutive sweeps after a good answer -> rd_stat goes 1000, 1001, 1010, 0011; rd_but keeps the last good value. 8 failures -> fail_cnt holds at 7.
- Hold io_busy=0 (model stalled) -> io_start drops after 4 clocks, a failure is recorded, and the poll advances to the next address.
- led_wr addr=0, data=16'hF00F while address 0 is being polled -> io_led stays at the old value for this exchange; the next poll of 0 drives F00F.
- enable dropped mid-exchange -> the exchange completes, STORE updates registers, the FSM reaches IDLE with io_start=0. Re-enable -> first io_n_mup=0.
- rst pulsed during START -> all outputs return to 0 asynchronously and rd_stat=0 for all addresses.

Source files
------------

// File: rtl/mup_poll.sv
// mup_poll: polling scheduler for the MUP control-panel bus.
// Sweeps panel addresses 0..N_MUP-1, runs one mup_io exchange per panel,
// and keeps per-panel LED / button / analog / link-health registers that
// the host reads and writes without touching the bus itself.
//
// Handshake with mup_io: io_start is held high until io_busy is seen (or
// four clocks pass with no io_busy). The exchange is finished on the first
// clock where io_busy is low again. io_answer, io_error, io_but and io_an
// are taken as valid in that STORE cycle.
module mup_poll #(
  parameter int N_MUP = 8,
  parameter int GAP   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        led_wr,
  input  logic [2:0]  led_addr,
  input  logic [15:0] led_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_but,
  output logic [23:0] rd_an,
  output logic [3:0]  rd_stat,
  output logic        cycle_done,
  output logic        io_start,
  output logic [2:0]  io_n_mup,
  output logic [15:0] io_led,
  input  logic        io_busy,
  input  logic        io_error,
  input  logic        io_answer,
  input  logic [15:0] io_but,
  input  logic [23:0] io_an,
  output logic [2:0]  fsm_state
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [2:0] LAST = 3'(N_MUP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_NEXT  = 3'd5,
    S_GAPW  = 3'd6
  } state_t;

  state_t          state;
  logic [2:0]      addr;
  logic [1:0]      start_cnt;
  logic [GW-1:0]   gap_cnt;

  // Storage is sized for the full 3-bit address space; entries at or above
  // N_MUP are never written, so they stay at zero.
  logic [15:0] led_mem  [8];
  logic [15:0] but_mem  [8];
  logic [23:0] an_mem   [8];
  logic [2:0]  fail_cnt [8];
  logic        online   [8];

  logic       led_ok;
  logic       rd_ok;
  logic       success;
  logic       do_store;
  logic       do_timeout;
  logic [2:0] fc_next;

  assign led_ok     = ({29'd0, led_addr} < 32'(N_MUP));
  assign rd_ok      = ({29'd0, rd_addr} < 32'(N_MUP));
  assign success    = io_answer & ~io_error;
  assign do_store   = (state == S_STORE);
  assign do_timeout = (state == S_START) && !io_busy && (start_cnt == 2'd3);
  assign fc_next    = (fail_cnt[addr] == 3'd7) ? 3'd7 : fail_cnt[addr] + 3'd1;
  assign fsm_state  = state;

  // Poll sequencer: one exchange per address, then a GAP-clock pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= 3'd0;
      start_cnt  <= 2'd0;
      gap_cnt    <= '0;
      io_start   <= 1'b0;
      io_n_mup   <= 3'd0;
      io_led     <= 16'd0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      case (state)
        S_IDLE: begin
          addr <= 3'd0;
          if (enable) state <= S_LOAD;
        end
        S_LOAD: begin
          // io_led is a snapshot: later LED writes wait for the next poll.
          io_n_mup  <= addr;
          io_led    <= led_mem[addr];
          io_start  <= 1'b1;
          start_cnt <= 2'd0;
          state     <= S_START;
        end
        S_START: begin
          if (io_busy) begin
            io_start <= 1'b0;
            state    <= S_WAIT;
          end else if (start_cnt == 2'd3) begin
            // mup_io never acknowledged: counted as a failed exchange.
            io_start   <= 1'b0;
            cycle_done <= enable && (addr == LAST);
            state      <= enable ? S_NEXT : S_IDLE;
          end else begin
            start_cnt <= start_cnt + 2'd1;
          end
        end
        S_WAIT: begin
          if (!io_busy) state <= S_STORE;
        end
        S_STORE: begin
          // A dropped enable lets the exchange finish here, then parks.
          cycle_done <= enable && (addr == LAST);
          state      <= enable ? S_NEXT : S_IDLE;
        end
        S_NEXT: begin
          addr    <= (addr == LAST) ? 3'd0 : addr + 3'd1;
          gap_cnt <= '0;
          state   <= S_GAPW;
        end
        S_GAPW: begin
          if (gap_cnt == GW'(GAP - 1)) state <= enable ? S_LOAD : S_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file: host LED writes and per-panel exchange results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        led_mem[i]  <= 16'd0;
        but_mem[i]  <= 16'd0;
        an_mem[i]   <= 24'd0;
        fail_cnt[i] <= 3'd0;
        online[i]   <= 1'b0;
      end
    end else begin
      if (led_wr && led_ok) led_mem[led_addr] <= led_data;
      if (do_store && success) begin
        but_mem[addr]  <= io_but;
        an_mem[addr]   <= io_an;
        fail_cnt[addr] <= 3'd0;
        online[addr]   <= 1'b1;
      end else if (do_store || do_timeout) begin
        // Button/analog data keep the last good answer.
        fail_cnt[addr] <= fc_next;
        if (fc_next >= 3'd3) online[addr] <= 1'b0;
      end
    end
  end

  // Host read port, one clock of latency; out-of-range reads give zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_but  <= 16'd0;
      rd_an   <= 24'd0;
      rd_stat <= 4'd0;
    end else if (rd_ok) begin
      rd_but  <= but_mem[rd_addr];
      rd_an   <= an_mem[rd_addr];
      rd_stat <= {online[rd_addr], fail_cnt[rd_addr]};
    end else begin
      rd_but  <= 16'd0;
      rd_an   <= 24'd0;
      rd_stat <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mup_poll.sv
// Bench for mup_poll with a small behavioural stand-in for mup_io/panels.
module tb_mup_poll;
  localparam int N_MUP = 4;
  localparam int GAP   = 3;
  localparam int W     = 44;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic        led_wr = 1'b0;
  logic [2:0]  led_addr = 3'd0;
  logic [15:0] led_data = 16'd0;
  logic [2:0]  rd_addr = 3'd0;
  logic [15:0] rd_but;
  logic [23:0] rd_an;
  logic [3:0]  rd_stat;
  logic        cycle_done;
  logic        io_start;
  logic [2:0]  io_n_mup;
  logic [15:0] io_led;
  logic        io_busy = 1'b0;
  logic        io_error = 1'b0;
  logic        io_answer = 1'b0;
  logic [15:0] io_but = 16'd0;
  logic [23:0] io_an = 24'd0;
  logic [2:0]  fsm_state;

  mup_poll #(.N_MUP(N_MUP), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .led_wr(led_wr), .led_addr(led_addr), .led_data(led_data),
    .rd_addr(rd_addr), .rd_but(rd_but), .rd_an(rd_an), .rd_stat(rd_stat),
    .cycle_done(cycle_done), .io_start(io_start), .io_n_mup(io_n_mup),
    .io_led(io_led), .io_busy(io_busy), .io_error(io_error),
    .io_answer(io_answer), .io_but(io_but), .io_an(io_an),
    .fsm_state(fsm_state)
  );

  // ---------------- panel / mup_io model ----------------
  logic        stall = 1'b0;
  logic [7:0]  ans_mask = 8'b0000_0100;
  logic [7:0]  perr_mask = 8'b0000_0000;
  logic [15:0] but_tab [8];
  logic [23:0] an_tab [8];
  logic [15:0] seen_led [8];
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [2:0]  m_addr = 3'd0;

  always @(negedge clk) begin : panel_model
    if (rst) begin
      m_phase = 0; io_busy = 1'b0; io_answer = 1'b0; io_error = 1'b0;
      io_but = 16'd0; io_an = 24'd0;
    end else begin
      case (m_phase)
        0: if (io_start && !stall) begin
             m_addr = io_n_mup; seen_led[m_addr] = io_led;
             io_answer = 1'b0; io_error = 1'b0; m_phase = 1;
           end
        1: begin io_busy = 1'b1; m_cnt = 0; m_phase = 2; end
        2: begin
             m_cnt++;
             if (m_cnt == 8) begin
               io_answer = ans_mask[m_addr]; io_error = perr_mask[m_addr];
               io_but = but_tab[m_addr]; io_an = an_tab[m_addr];
               io_busy = 1'b0; m_phase = 3;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic rd_pend = 1'b0;
  logic rd_stage = 1'b0;
  int total = 0;
  int bad = 0;
  int cd_count = 0;
  int cd_wide = 0;
  logic cd_prev = 1'b0;

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rd_stage) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL read_scoreboard: read result with empty queue");
      end else begin
        e = exp_q.pop_front();
        if ({rd_but, rd_an, rd_stat} !== e) begin
          bad++;
          $display("FAIL read addr=%0d: got but=%h an=%h stat=%b, want but=%h an=%h stat=%b",
                   rd_addr, rd_but, rd_an, rd_stat, e[43:28], e[27:4], e[3:0]);
        end
      end
    end
    rd_stage = rd_pend;
    if (cycle_done) begin
      cd_count++;
      if (cd_prev) cd_wide++;
    end
    cd_prev = cycle_done;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++; bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [15:0] b,
                         input logic [23:0] n, input logic [3:0] s);
    rd_addr = a;
    exp_q.push_back({b, n, s});
    rd_pend = 1'b1;
    tick();
    rd_pend = 1'b0;
    tick();
    tick();
  endtask

  task automatic led_write(input logic [2:0] a, input logic [15:0] d);
    led_addr = a; led_data = d; led_wr = 1'b1;
    tick();
    led_wr = 1'b0;
  endtask

  task automatic wait_cd(input string name);
    int n = 0;
    while (!cycle_done && n < 2000) begin tick(); n++; end
    if (!cycle_done) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (fsm_state != 3'd0 && n < 2000) begin tick(); n++; end
    if (fsm_state != 3'd0) timeout_fail(name);
  endtask

  task automatic wait_start_rise(input string name);
    int n = 0;
    while (io_start && n < 2000) begin tick(); n++; end
    while (!io_start && n < 2000) begin tick(); n++; end
    if (!io_start) timeout_fail(name);
  endtask

  task automatic wait_busy_addr(input string name, input logic [2:0] a);
    int n = 0;
    while (!(io_busy && io_n_mup == a) && n < 2000) begin tick(); n++; end
    if (!(io_busy && io_n_mup == a)) timeout_fail(name);
  endtask

  task automatic run_sweep(input string name);
    enable = 1'b1;
    wait_cd(name);
    enable = 1'b0;
    wait_idle(name);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] led_init [4];
  logic [3:0]  par_stat [3];

  initial begin
    for (int i = 0; i < 8; i++) begin
      but_tab[i] = 16'd0; an_tab[i] = 24'd0; seen_led[i] = 16'd0;
    end
    but_tab[2] = 16'hA55A; an_tab[2] = 24'h123456;
    led_init[0] = 16'h1111; led_init[1] = 16'h2222;
    led_init[2] = 16'h3333; led_init[3] = 16'h4444;
    par_stat[0] = 4'b1001; par_stat[1] = 4'b1010; par_stat[2] = 4'b0011;

    // Reset values
    rst = 1'b1;
    tick(); tick();
    check("reset io_start", {31'd0, io_start}, 32'd0);
    check("reset io_n_mup", {29'd0, io_n_mup}, 32'd0);
    check("reset io_led", {16'd0, io_led}, 32'd0);
    check("reset cycle_done", {31'd0, cycle_done}, 32'd0);
    check("reset rd_stat", {28'd0, rd_stat}, 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) do_read(3'(i), 16'd0, 24'd0, 4'd0);

    // First sweep: only address 2 answers
    for (int i = 0; i < 4; i++) led_write(3'(i), led_init[i]);
    led_write(3'd5, 16'hDEAD);
    run_sweep("sweep1");
    for (int i = 0; i < 4; i++) check("sweep1 io_led", {16'd0, seen_led[i]}, {16'd0, led_init[i]});
    do_read(3'd2, 16'hA55A, 24'h123456, 4'b1000);
    do_read(3'd0, 16'd0, 24'd0, 4'b0001);
    do_read(3'd1, 16'd0, 24'd0, 4'b0001);
    do_read(3'd3, 16'd0, 24'd0, 4'b0001);
    do_read(3'd5, 16'd0, 24'd0, 4'b0000);
    check("sweep1 cycle_done count", cd_count, 32'd1);

    // Stalled mup_io: start held 4 clocks, failure recorded, poll advances
    stall = 1'b1;
    enable = 1'b1;
    wait_start_rise("stall start0");
    check("stall first addr", {29'd0, io_n_mup}, 32'd0);
    begin
      int n = 0;
      while (io_start && n < 20) begin n++; tick(); end
      check("stall io_start width", n, 32'd4);
    end
    wait_start_rise("stall start1");
    check("stall next addr", {29'd0, io_n_mup}, 32'd1);
    enable = 1'b0;
    wait_idle("stall idle");
    stall = 1'b0;
    do_read(3'd0, 16'd0, 24'd0, 4'b0010);
    do_read(3'd1, 16'd0, 24'd0, 4'b0010);

    // Address 1 answers, then parity errors on it
    ans_mask = 8'b0000_0110;
    but_tab[1] = 16'hBEEF; an_tab[1] = 24'hABCDEF;
    run_sweep("good1");
    do_read(3'd1, 16'hBEEF, 24'hABCDEF, 4'b1000);
    do_read(3'd6, 16'd0, 24'd0, 4'b0000);
    do_read(3'd2, 16'hA55A, 24'h123456, 4'b1000);
    perr_mask[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_sweep("perr");
      do_read(3'd1, 16'hBEEF, 24'hABCDEF, par_stat[k]);
    end
    for (int k = 0; k < 5; k++) run_sweep("perr_sat");
    do_read(3'd1, 16'hBEEF, 24'hABCDEF, 4'b0111);
    do_read(3'd0, 16'd0, 24'd0, 4'b0111);
    do_read(3'd3, 16'd0, 24'd0, 4'b0111);
    check("cycle_done count after sweeps", cd_count, 32'd10);

    // LED write to the address being polled
    enable = 1'b1;
    wait_busy_addr("led busy0", 3'd0);
    led_write(3'd0, 16'hF00F);
    tick();
    check("led held during poll", {16'd0, io_led}, 32'h1111);
    wait_cd("led sweep");
    wait_start_rise("led next poll");
    check("led next poll addr", {29'd0, io_n_mup}, 32'd0);
    check("led next poll value", {16'd0, io_led}, 32'hF00F);
    enable = 1'b0;
    wait_idle("led idle");
    check("led model saw", {16'd0, seen_led[0]}, 32'hF00F);

    // enable dropped mid-exchange of address 2
    but_tab[2] = 16'h5AA5;
    enable = 1'b1;
    wait_busy_addr("drop busy2", 3'd2);
    enable = 1'b0;
    wait_idle("drop idle");
    check("drop io_start", {31'd0, io_start}, 32'd0);
    check("drop no cycle_done", cd_count, 32'd11);
    do_read(3'd2, 16'h5AA5, 24'h123456, 4'b1000);
    do_read(3'd3, 16'd0, 24'd0, 4'b0111);
    enable = 1'b1;
    wait_start_rise("reenable");
    check("reenable first addr", {29'd0, io_n_mup}, 32'd0);

    // Reset pulsed while in START
    rst = 1'b1;
    #1;
    check("rst io_start", {31'd0, io_start}, 32'd0);
    check("rst io_n_mup", {29'd0, io_n_mup}, 32'd0);
    check("rst io_led", {16'd0, io_led}, 32'd0);
    check("rst rd_stat", {28'd0, rd_stat}, 32'd0);
    check("rst fsm idle", {29'd0, fsm_state}, 32'd0);
    enable = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) do_read(3'(i), 16'd0, 24'd0, 4'd0);

    tick(); tick();
    check("cycle_done pulse width", cd_wide, 32'd0);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
